fizzbuzz_seq: RTL and testbench

- Sequencer that sweeps an unsigned range [start_n, end_n] one value per handshake and classifies each value as fizz (divisible by 3) and/or buzz (divisible by 5).
- Replaces per-value `%` hardware with a one-time modulo-15 reduction of start_n, followed by incrementing residue counters.
- Sits between a command source (start pulse) and a downstream consumer using a valid/ready stream.

---
 rtl/fizzbuzz_pkg.sv | 38 +++
 rtl/fizzbuzz_seq_mod_counter.sv | 25 ++
 rtl/fizzbuzz_seq.sv | 141 ++++++++++++++
 tb/tb_fizzbuzz_seq.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fizzbuzz_pkg.sv
// Shared types and constants for the fizzbuzz sequencer.
// Residue lookups cover the 0..14 range left after mod-15 reduction.
package fizzbuzz_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REDUCE,
        RUN,
        DONE
    } state_t;

    localparam int MOD3  = 3;
    localparam int MOD5  = 5;
    localparam int MOD15 = 15;

    function automatic logic [1:0] res3_of(input logic [3:0] v);
        logic [1:0] r;
        case (v)
            4'd0, 4'd3, 4'd6, 4'd9, 4'd12:  r = 2'd0;
            4'd1, 4'd4, 4'd7, 4'd10, 4'd13: r = 2'd1;
            default:                        r = 2'd2;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] res5_of(input logic [3:0] v);
        logic [2:0] r;
        case (v)
            4'd0, 4'd5, 4'd10: r = 3'd0;
            4'd1, 4'd6, 4'd11: r = 3'd1;
            4'd2, 4'd7, 4'd12: r = 3'd2;
            4'd3, 4'd8, 4'd13: r = 3'd3;
            default:           r = 3'd4;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fizzbuzz_seq_mod_counter.sv
// Wrapping residue register: counts 0..MOD-1 with a parallel load.
// Load has priority over increment.
module mod_counter #(
    parameter int MOD = 3,
    localparam int CW = $clog2(MOD)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          inc,
    output logic [CW-1:0] value
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (inc) begin
            value <= (value == CW'(MOD - 1)) ? '0 : value + CW'(1);
        end
    end

endmodule

// File: rtl/fizzbuzz_seq.sv
// Sweeps [start_n, end_n] over a valid/ready stream, tagging fizz/buzz
// from residue counters seeded by a one-time mod-15 reduction.
module fizzbuzz_seq
    import fizzbuzz_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] start_n,
    input  logic [W-1:0] end_n,
    output logic         busy,
    output logic         done,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_n,
    output logic         out_fizz,
    output logic         out_buzz,
    output logic         out_last
);

    state_t       state;
    state_t       state_nx;
    logic [W-1:0] n;
    logic [W-1:0] end_q;
    logic [W-1:0] r15;
    logic [1:0]   res3;
    logic [2:0]   res5;
    logic         accept;
    logic         fire;
    logic         reduce_done;
    logic         step;

    assign accept      = (state == IDLE) && start;
    assign fire        = out_valid && out_ready;
    assign reduce_done = (state == REDUCE) && (r15 < W'(MOD15));
    // Increment only below end_n, so n never wraps past 2^W-1.
    assign step        = fire && !out_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (end_n < start_n) ? DONE : REDUCE;
                end
            end
            REDUCE: begin
                if (r15 < W'(MOD15)) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (fire && out_last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        out_valid = 1'b0;
        out_fizz  = 1'b0;
        out_buzz  = 1'b0;
        out_last  = 1'b0;
        unique case (1'b1)
            (state == REDUCE): begin
                busy = 1'b1;
            end
            (state == RUN): begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_fizz  = (res3 == 2'd0);
                out_buzz  = (res5 == 3'd0);
                out_last  = (n == end_q);
            end
            (state == DONE): begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign out_n = n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n     <= '0;
            end_q <= '0;
            r15   <= '0;
        end else if (accept) begin
            n     <= start_n;
            r15   <= start_n;
            end_q <= end_n;
        end else if ((state == REDUCE) && !reduce_done) begin
            r15 <= r15 - W'(MOD15);
        end else if (step) begin
            n <= n + W'(1);
        end
    end

    mod_counter #(
        .MOD(MOD3)
    ) u_res3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (reduce_done),
        .load_val (res3_of(r15[3:0])),
        .inc      (step),
        .value    (res3)
    );

    mod_counter #(
        .MOD(MOD5)
    ) u_res5 (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (reduce_done),
        .load_val (res5_of(r15[3:0])),
        .inc      (step),
        .value    (res5)
    );

endmodule

// File: tb/tb_fizzbuzz_seq.sv
// Bench for fizzbuzz_seq: directed cases plus random ranges and stalls,
// checked against a per-value model built with plain % arithmetic.
module tb_fizzbuzz_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] start_n = '0;
    logic [7:0] end_n = '0;
    logic       busy;
    logic       done;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_n;
    logic       out_fizz;
    logic       out_buzz;
    logic       out_last;

    int n_tests = 0;
    int n_fail = 0;

    fizzbuzz_seq #(.W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .start_n   (start_n),
        .end_n     (end_n),
        .busy      (busy),
        .done      (done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_n     (out_n),
        .out_fizz  (out_fizz),
        .out_buzz  (out_buzz),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Beat word: {valid, n, fizz, buzz, last}
    function automatic logic [11:0] beat_obs();
        return {out_valid, out_n, out_fizz, out_buzz, out_last};
    endfunction

    task automatic run_cmd(input int s, input int e, input int stall_first,
                           input bit rand_stall, input bit inject);
        logic [11:0] exp_q[$];
        int          cyc;
        int          nbeats;
        int          stalls;
        bit          rdy;
        bit          full_rate;
        full_rate = (stall_first == 0) && !rand_stall;
        stalls = stall_first;
        for (int v = s; v <= e; v++) begin
            exp_q.push_back({1'b1, 8'(v), v % 3 == 0, v % 5 == 0, v == e});
        end
        nbeats = exp_q.size();

        @(negedge clk);
        start   = 1'b1;
        start_n = 8'(s);
        end_n   = 8'(e);
        @(negedge clk);
        start = 1'b0;

        if (e < s) begin
            chk("empty_done", {31'd0, done}, 32'd1);
            chk("empty_valid", {31'd0, out_valid}, 32'd0);
            @(negedge clk);
            chk("empty_idle", {30'd0, busy, done}, 32'd0);
            return;
        end

        chk("reduce_busy", {31'd0, busy}, 32'd1);
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            chk("reduce_novalid", {31'd0, done}, 32'd0);
            @(negedge clk);
            cyc++;
        end
        chk("first_latency", cyc, s / 15 + 2);

        cyc = 0;
        while (exp_q.size() > 0 && cyc < 2000) begin
            chk($sformatf("beat_%0d", exp_q[0][10:3]), {20'd0, beat_obs()},
                {20'd0, exp_q[0]});
            if (stalls > 0) begin
                rdy = 1'b0;
                stalls--;
            end else begin
                rdy = rand_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            out_ready = rdy;
            if (inject && cyc == 1) begin
                start   = 1'b1;
                start_n = 8'd0;
                end_n   = 8'd0;
            end else begin
                start = 1'b0;
            end
            if (rdy) void'(exp_q.pop_front());
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b0;
        chk("beats_left", exp_q.size(), 0);
        if (full_rate) chk("throughput", cyc, nbeats);
        chk("done_pulse", {30'd0, done, out_valid}, 32'd2);
        @(negedge clk);
        chk("back_idle", {29'd0, busy, done, out_valid}, 32'd0);
    endtask

    initial begin
        int s;
        int e;
        int c;
        repeat (2) @(negedge clk);
        chk("reset_outs", {18'd0, busy, done, out_valid, out_fizz,
            out_buzz, out_last, out_n}, 32'd0);
        rst_n = 1'b1;

        run_cmd(1, 15, 0, 0, 0);
        run_cmd(200, 202, 0, 0, 0);
        run_cmd(9, 10, 5, 0, 0);
        run_cmd(250, 255, 0, 0, 0);
        chk("no_wrap_beat", {31'd0, out_valid}, 32'd0);
        run_cmd(7, 3, 0, 0, 0);
        run_cmd(3, 6, 0, 0, 1);

        // Reset during a stalled beat.
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b1;
        start_n   = 8'd9;
        end_n     = 8'd10;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (!out_valid && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_outs", {18'd0, busy, done, out_valid, out_fizz,
            out_buzz, out_last, out_n}, 32'd0);
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_quiet", {29'd0, busy, done, out_valid}, 32'd0);
        end
        out_ready = 1'b0;
        run_cmd(0, 0, 0, 0, 0);

        for (int i = 0; i < 25; i++) begin
            s = $urandom_range(0, 255);
            if ($urandom_range(0, 7) == 0) begin
                e = $urandom_range(0, 255);
            end else begin
                e = s + $urandom_range(0, (255 - s) < 20 ? (255 - s) : 20);
            end
            run_cmd(s, e, $urandom_range(0, 2), 1, $urandom_range(0, 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
